// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - fetch sequencer control/instruction-memory bundle
interface pc_fetch_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_target;
    logic             halt;
    logic             imem_ready;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic [31:0]      pc;
    logic             fetch_valid;
    logic [31:0]      fetch_pc;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;
    logic             misalign_err;

    // Sequencer side: owns the PC and drives the memory request
    modport master (
        input  stall, redirect, redirect_target, halt, imem_ready,
        output imem_req, imem_addr, pc, fetch_valid, fetch_pc, halted,
               fetch_count, misalign_err
    );

    // Hazard/branch units, instruction memory and decode side
    modport slave (
        output stall, redirect, redirect_target, halt, imem_ready,
        input  imem_req, imem_addr, pc, fetch_valid, fetch_pc, halted,
               fetch_count, misalign_err
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - PC register and fetch handshake sequencer (option macro: PC_ALIGN_CHECK_EN)
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0004_0000,
    parameter int          PC_STEP      = 4,
    parameter int          CNT_W        = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pc_fetch_sequencer_if.master bus
);
    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic             misalign_q, misalign_d;
    logic             target_bad;

`ifdef PC_ALIGN_CHECK_EN
    // A redirect to a non-word-aligned target is refused and stops the fetch stage
    assign target_bad = (bus.redirect_target[1:0] != 2'b00);
`else
    assign target_bad = 1'b0;
`endif

    // Next-state selection: halt > redirect > stall > memory ready
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = 1'b0;
        fetch_pc_d    = fetch_pc_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = misalign_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (bus.redirect) begin
                    // Any completion in this cycle belongs to the old path and is dropped
                    if (target_bad) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d = bus.redirect_target;
                    end
                end else if (bus.stall) begin
                    // Completion discarded; the same PC is requested again after the stall
                    state_d = ST_STALL;
                end else if (bus.imem_ready) begin
                    fetch_valid_d = 1'b1;
                    fetch_pc_d    = pc_q;
                    fetch_count_d = fetch_count_q + 1'b1;
                    pc_d          = pc_q + STEP;
                end
            end
            ST_STALL: begin
                if (bus.halt) begin
                    state_d = ST_HALT;
                end else if (bus.redirect) begin
                    if (target_bad) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d = bus.redirect_target;
                        if (!bus.stall) begin
                            state_d = ST_FETCH;
                        end
                    end
                end else if (!bus.stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    // Register update with synchronous active-low reset overriding everything
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'h0;
            fetch_count_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.imem_req     = (state_q == ST_FETCH);
    assign bus.imem_addr    = pc_q;
    assign bus.pc           = pc_q;
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.fetch_pc     = fetch_pc_q;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.fetch_count  = fetch_count_q;
    assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - randomized self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;
    localparam logic [31:0] RV = 32'h0004_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk;
    logic rst;
    pc_fetch_sequencer_if #(.CNT_W(16)) bus ();

    pc_fetch_sequencer #(.RESET_VECTOR(RV), .PC_STEP(4), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: what the fetch stage is doing, in plain terms
    bit          m_booting, m_running, m_frozen, m_stopped;
    logic [31:0] m_pc, m_fpc;
    bit          m_fv, m_mis;
    int unsigned m_cnt;
    logic [31:0] fetch_log[$];
    logic [31:0] saved_pc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booting = 1; m_running = 0; m_frozen = 0; m_stopped = 0;
        m_pc = RV; m_fpc = 32'h0; m_fv = 0; m_mis = 0; m_cnt = 0;
    endtask

    // Apply one clock edge worth of behaviour to the model
    task automatic model_step(input bit r, input bit s, input bit rd, input logic [31:0] t,
                              input bit h, input bit rdy);
        bit bad;
        bad = ALIGN_CHK && (t % 4 != 0);
        m_fv = 0;
        if (!r) begin
            model_reset();
        end else if (m_booting) begin
            m_booting = 0; m_running = 1;
        end else if (m_running || m_frozen) begin
            if (h) begin
                m_running = 0; m_frozen = 0; m_stopped = 1;
            end else if (rd && bad) begin
                m_mis = 1; m_running = 0; m_frozen = 0; m_stopped = 1;
            end else if (rd) begin
                m_pc = t;
                if (m_frozen && !s) begin m_frozen = 0; m_running = 1; end
            end else if (m_running && s) begin
                m_running = 0; m_frozen = 1;
            end else if (m_frozen && !s) begin
                m_frozen = 0; m_running = 1;
            end else if (m_running && rdy) begin
                m_fv = 1; m_fpc = m_pc; m_cnt = (m_cnt + 1) % 65536;
                m_pc = (m_pc + 32'd4);
            end
        end
    endtask

    task automatic compare_all();
        check_eq("pc", bus.pc, m_pc);
        check_eq("imem_addr", bus.imem_addr, m_pc);
        check_eq("imem_req", 32'(bus.imem_req), 32'(m_running));
        check_eq("fetch_valid", 32'(bus.fetch_valid), 32'(m_fv));
        check_eq("fetch_pc", bus.fetch_pc, m_fpc);
        check_eq("halted", 32'(bus.halted), 32'(m_stopped));
        check_eq("fetch_count", 32'(bus.fetch_count), m_cnt);
        check_eq("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
        if (bus.fetch_valid === 1'b1) fetch_log.push_back(bus.fetch_pc);
    endtask

    // Compare on the falling edge, then present the next cycle's inputs
    task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] t,
                        input bit h, input bit rdy);
        @(negedge clk);
        compare_all();
        rst = r; bus.stall = s; bus.redirect = rd; bus.redirect_target = t;
        bus.halt = h; bus.imem_ready = rdy;
        model_step(r, s, rd, t, h, rdy);
    endtask

    initial begin
        rst = 0; bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0;
        bus.halt = 0; bus.imem_ready = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);

        // Reset then free-run with ready held high
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check_eq("boot_req", 32'(bus.imem_req), 32'd0);
        fetch_log.delete();
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        check_eq("cnt3", 32'(bus.fetch_count), 32'd3);
        check_eq("log_len", fetch_log.size(), 32'd3);
        if (fetch_log.size() >= 3) begin
            check_eq("fpc0", fetch_log[0], 32'h0004_0000);
            check_eq("fpc1", fetch_log[1], 32'h0004_0004);
            check_eq("fpc2", fetch_log[2], 32'h0004_0008);
        end

        // Wait states hold the request and address steady
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0);
            check_eq("wait_req", 32'(bus.imem_req), 32'd1);
            check_eq("wait_addr", bus.imem_addr, 32'h0004_0000);
            check_eq("wait_fv", 32'(bus.fetch_valid), 32'd0);
        end
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check_eq("wait_done_fv", 32'(bus.fetch_valid), 32'd1);
        check_eq("wait_done_fpc", bus.fetch_pc, 32'h0004_0000);

        // Redirect with a coincident ready at pc 0x00040008
        step(1, 0, 0, 0, 0, 0);
        check_eq("pre_redir_pc", bus.pc, 32'h0004_0008);
        step(1, 0, 1, 32'h0004_0100, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check_eq("flush_fv", 32'(bus.fetch_valid), 32'd0);
        check_eq("flush_cnt", 32'(bus.fetch_count), 32'd2);
        step(1, 0, 0, 0, 0, 0);
        check_eq("redir_fpc", bus.fetch_pc, 32'h0004_0100);

        // Stall for four cycles with a redirect in the second
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 1, 32'h0004_1000, 0, 1);
        check_eq("stall_req1", 32'(bus.imem_req), 32'd0);
        step(1, 1, 0, 0, 0, 1);
        check_eq("stall_req2", 32'(bus.imem_req), 32'd0);
        step(1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        check_eq("post_stall_fpc", bus.fetch_pc, 32'h0004_1000);

        // Wrap of the PC, then reset during a pending request
        step(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        check_eq("wrap_fpc0", bus.fetch_pc, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0);
        check_eq("wrap_fpc1", bus.fetch_pc, 32'h0000_0000);
        check_eq("wrap_pc", bus.pc, 32'h0000_0004);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        check_eq("mid_rst_pc", bus.pc, 32'h0004_0000);
        check_eq("mid_rst_req", 32'(bus.imem_req), 32'd0);

        // Halt freezes everything until reset
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        saved_pc = m_pc;
        for (int i = 0; i < 10; i++) begin
            step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, 0, 1);
            check_eq("halt_flag", 32'(bus.halted), 32'd1);
            check_eq("halt_pc", bus.pc, saved_pc);
        end

`ifdef PC_ALIGN_CHECK_EN
        // Misaligned redirect is refused and halts the stage
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h0004_0102, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        check_eq("mis_err", 32'(bus.misalign_err), 32'd1);
        check_eq("mis_halted", 32'(bus.halted), 32'd1);
        check_eq("mis_pc", bus.pc, 32'h0004_0000);
`endif
        step(0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8 | (t & 32'h7);
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0),
                 t,
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 1) == 1));
        end
        @(negedge clk);
        compare_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Controls the program counter and instruction-memory fetch handshake for the uPOWER instruction-fetch stage. Owns the PC register and selects the next PC:
- reset vector
- sequential PC+4
- branch/jump redirect target
- hold on stall or halt

Sits between the hazard/branch units and instruction memory. Delivers a valid (PC, fetch) pulse to the decode stage.

Parameters:
RESET_VECTOR, 32'h0004_0000, PC value loaded on reset.
PC_STEP, 4, sequential increment in bytes.
CNT_W, 16, width of the fetch counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
stall  input  1  hazard unit requests fetch freeze.
redirect  input  1  branch/jump taken; load redirect_target.
redirect_target  input  32  new PC on redirect.
halt  input  1  stop fetching until reset.
imem_ready  input  1  instruction memory accepts/completes the current request this cycle.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; always equals pc.
pc  output  32  current PC register.
fetch_valid  output  1  one-cycle pulse: a fetch completed.
fetch_pc  output  32  PC of the completed fetch; valid when fetch_valid=1.
halted  output  1  sequencer is in HALT.
fetch_count  output  CNT_W  number of completed fetches, wraps.
misalign_err  output  1  see Optional Feature; constant 0 when feature is compiled out.

Behaviour:
- States: BOOT, FETCH, STALL, HALT. Encoding is free.
- Reset (rst==0 at posedge clk):
  - state=BOOT, pc=RESET_VECTOR.
  - imem_req=0, fetch_valid=0, fetch_pc=0, halted=0, fetch_count=0, misalign_err=0.
  - Reset overrides all other inputs, in any state and mid-handshake.
- BOOT:
  - imem_req=0.
  - Next cycle -> FETCH unconditionally; inputs ignored.
- FETCH:
  - imem_req=1 combinationally.
  - Event priority per cycle: halt > redirect > stall > imem_ready.
  - halt=1 -> HALT; pc held; no fetch_valid.
  - redirect=1 -> pc<=redirect_target; stay FETCH. A coincident imem_ready is flushed: no fetch_valid, no count.
  - stall=1 -> STALL; pc held. A coincident imem_ready is discarded; the same PC is refetched later.
  - imem_ready=1 -> next cycle fetch_valid=1, fetch_pc=old pc, fetch_count+1. pc<=pc+PC_STEP; stay FETCH.
  - Otherwise -> hold pc; imem_req stays high. imem_addr must not change while the request is pending.
- STALL:
  - imem_req=0.
  - halt=1 -> HALT.
  - redirect=1 -> pc<=redirect_target. Stay STALL if stall=1, else -> FETCH.
  - stall=0 -> FETCH next cycle.
- HALT:
  - halted=1, imem_req=0.
  - pc is frozen; all inputs except rst are ignored. Exit only via reset.
- Latency: imem_ready at edge N -> fetch_valid high in cycle N+1. Back-to-back ready gives one fetch per cycle.
- fetch_valid is registered and is a single-cycle pulse per accepted fetch.
- Arithmetic:
  - pc+PC_STEP is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
  - fetch_count wraps at 2^CNT_W-1 -> 0.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_target[1:0]!=0 is rejected and pc is held.
  - misalign_err=1 on the next cycle and stays high (sticky).
  - State -> HALT.
  - Only reset clears misalign_err.
- Not defined: redirect_target is loaded unmodified; misalign_err tied to 0.

Test Plan:
- Reset then free-run: rst=0 for 2 cycles, then rst=1, imem_ready=1 constant -> BOOT for 1 cycle. fetch_pc sequence 0x00040000, 0x00040004, 0x00040008; fetch_count reaches 3 after 3 fetch_valid pulses.
- Wait states: imem_ready=0 for 3 cycles in FETCH -> imem_req=1 and imem_addr=0x00040000 held steady, no fetch_valid. Then ready=1 -> single fetch_valid with fetch_pc=0x00040000.
- Redirect with coincident ready: at pc=0x00040008 assert redirect=1, target=0x00040100, imem_ready=1 -> no fetch_valid for 0x00040008; next fetch_pc=0x00040100; count unchanged by flushed fetch.
- Stall and redirect-in-stall: stall=1 for 4 cycles with redirect=1 (target 0x00041000) in cycle 2 -> imem_req=0 throughout. After stall drops, first fetch_pc=0x00041000.
- Wrap and mid-operation reset: redirect to 0xFFFFFFFC, ready=1 -> fetch_pc 0xFFFFFFFC then 0x00000000. Then rst=0 during pending request -> pc=0x00040000, imem_req=0 next cycle.
- Halt and alignment: halt=1 -> halted=1, pc frozen for 10 cycles despite ready/redirect. With PC_ALIGN_CHECK_EN, redirect to 0x00040102 -> misalign_err=1, halted=1, pc unchanged.
